// File: rtl/load_store_unit_if.sv
// Request/response and dataMemory bundle for load_store_unit.
// slave is the LSU side; master is the datapath/memory environment side.
interface load_store_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic        done;
  logic        busy;
  logic        misaligned;
  logic [31:0] memAddress;
  logic [31:0] memDataOut;
  logic [31:0] memDataIn;
  logic        memRead;
  logic        memWrite;

  modport slave (
    input  start, op, addr, storeData, memDataIn,
    output loadData, done, busy, misaligned, memAddress, memDataOut, memRead, memWrite
  );

  modport master (
    output start, op, addr, storeData, memDataIn,
    input  loadData, done, busy, misaligned, memAddress, memDataOut, memRead, memWrite
  );
endinterface

// File: rtl/load_store_unit.sv
// Multicycle byte-addressed load/store sequencer in front of a word-indexed dataMemory.
// Define LSU_MISALIGN_CHECK_EN to abort misaligned word/halfword requests.
module load_store_unit #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);
  localparam logic [2:0] OpLw  = 3'd0;
  localparam logic [2:0] OpLh  = 3'd1;
  localparam logic [2:0] OpLhu = 3'd2;
  localparam logic [2:0] OpLb  = 3'd3;
  localparam logic [2:0] OpLbu = 3'd4;
  localparam logic [2:0] OpSw  = 3'd5;
  localparam logic [2:0] OpSh  = 3'd6;
  localparam logic [2:0] OpSb  = 3'd7;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [31:0] wdata_q;
  logic [31:0] load_q;
  logic        accept;
  logic        req_mis;
  logic        sub_store;
  logic [1:0]  byte_idx;
  logic        half_idx;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged;

  assign accept    = (state_q == StIdle) && bus.start;
  assign sub_store = (op_q == OpSh) || (op_q == OpSb);

`ifdef LSU_MISALIGN_CHECK_EN
  logic mis_q;

  always_comb begin
    req_mis = 1'b0;
    case (bus.op)
      OpLw, OpSw:        req_mis = |bus.addr[1:0];
      OpLh, OpLhu, OpSh: req_mis = bus.addr[0];
      default:           req_mis = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= req_mis;
    end
  end

  assign bus.misaligned = (state_q == StDone) && mis_q;
`else
  assign req_mis        = 1'b0;
  assign bus.misaligned = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (req_mis)             state_d = StDone;
          else if (bus.op == OpSw) state_d = StWrite;
          else                     state_d = StRead;
        end
      end
      StRead:  state_d = sub_store ? StWrite : StDone;
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Byte offset 0 sits in the top lane when big-endian.
  assign byte_idx = BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0];
  assign half_idx = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];
  assign rd_byte  = bus.memDataIn[{byte_idx, 3'b000} +: 8];
  assign rd_half  = bus.memDataIn[{half_idx, 4'b0000} +: 16];

  always_comb begin
    load_ext = bus.memDataIn;
    case (op_q)
      OpLh:    load_ext = {{16{rd_half[15]}}, rd_half};
      OpLhu:   load_ext = {16'h0000, rd_half};
      OpLb:    load_ext = {{24{rd_byte[7]}}, rd_byte};
      OpLbu:   load_ext = {24'h000000, rd_byte};
      default: load_ext = bus.memDataIn;
    endcase
  end

  always_comb begin
    merged = bus.memDataIn;
    if (op_q == OpSh) begin
      merged[{half_idx, 4'b0000} +: 16] = sdata_q[15:0];
    end else begin
      merged[{byte_idx, 3'b000} +: 8] = sdata_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      wdata_q <= '0;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.op;
        addr_q  <= bus.addr;
        sdata_q <= bus.storeData;
        if (bus.op == OpSw) begin
          wdata_q <= bus.storeData;
        end
      end
      if (state_q == StRead) begin
        if (sub_store) begin
          wdata_q <= merged;
        end else begin
          load_q <= load_ext;
        end
      end
    end
  end

  assign bus.done       = (state_q == StDone);
  assign bus.busy       = (state_q != StIdle);
  assign bus.memRead    = (state_q == StRead) && !reset;
  assign bus.memWrite   = (state_q == StWrite) && !reset;
  assign bus.memAddress = {2'b00, addr_q[31:2]};
  assign bus.memDataOut = wdata_q;
  assign bus.loadData   = load_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level memory model, directed literals, randomized requests.
module tb_load_store_unit;
  localparam bit BE = 1'b1;

  logic clk = 1'b0;
  logic reset;
  load_store_unit_if bus();

  load_store_unit #(.BIG_ENDIAN(BE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [7:0]  rb  [1024];
  logic [31:0] exp_load;
  int          checks = 0;
  int          errors = 0;
  int          rd_cycles = 0;
  int          wr_cycles = 0;

  assign bus.memDataIn = mem[bus.memAddress[7:0]];

  always @(posedge clk) begin
    if (bus.memWrite) mem[bus.memAddress[7:0]] <= bus.memDataOut;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte k of a word lives in lane 3-k when big-endian.
  function automatic int lane(input int k);
    return BE ? 3 - k : k;
  endfunction

  function automatic logic [31:0] mword(input int w);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*lane(k) +: 8] = rb[4*w + k];
    return v;
  endfunction

  task automatic set_word(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int k = 0; k < 4; k++) rb[4*w + k] = v[8*lane(k) +: 8];
  endtask

  function automatic bit is_mis(input logic [2:0] op, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    if (op == 3'd0 || op == 3'd5) return a[1:0] != 2'b00;
    if (op == 3'd1 || op == 3'd2 || op == 3'd6) return a[0];
    return 1'b0;
`else
    return (op == 3'd7) && (a[0] && !a[0]);
`endif
  endfunction

  function automatic logic [31:0] exp_ld(input logic [2:0] op, input logic [31:0] a);
    int ea, hb;
    logic [15:0] h;
    logic [7:0] b;
    ea = int'(a[9:0]);
    hb = ea & ~1;
    b  = rb[ea];
    h  = BE ? {rb[hb], rb[hb + 1]} : {rb[hb + 1], rb[hb]};
    case (op)
      3'd0:    return mword(ea / 4);
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {16'h0000, h};
      3'd3:    return {{24{b[7]}}, b};
      3'd4:    return {24'h000000, b};
      default: return 32'h0;
    endcase
  endfunction

  task automatic apply_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    int ea, hb, wb;
    ea = int'(a[9:0]);
    hb = ea & ~1;
    wb = ea & ~3;
    if (op == 3'd5) begin
      for (int k = 0; k < 4; k++) rb[wb + k] = d[8*lane(k) +: 8];
    end else if (op == 3'd6) begin
      rb[hb]     = BE ? d[15:8] : d[7:0];
      rb[hb + 1] = BE ? d[7:0] : d[15:8];
    end else if (op == 3'd7) begin
      rb[ea] = d[7:0];
    end
  endtask

  always @(negedge clk) begin
    if (bus.memRead) rd_cycles++;
    if (bus.memWrite) wr_cycles++;
    if (!reset) begin
      check("strobe_exclusive", {31'b0, bus.memRead & bus.memWrite}, 32'd0);
      if (!bus.done) check("load_hold", bus.loadData, exp_load);
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                        input bit inject, output logic [31:0] ld, output logic mis);
    int cyc, lat, w;
    bit seen, m;
    m   = is_mis(op, a);
    w   = int'(a[9:2]);
    lat = m ? 1 : ((op == 3'd6 || op == 3'd7) ? 3 : 2);
    @(negedge clk);
    rd_cycles     = 0;
    wr_cycles     = 0;
    bus.start     = 1'b1;
    bus.op        = op;
    bus.addr      = a;
    bus.storeData = d;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.op        = 3'($urandom);
    bus.addr      = $urandom;
    bus.storeData = $urandom;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1'b1;
      else if (inject) begin
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.addr  = 32'($urandom_range(0, 1023));
      end
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    check("latency", 32'(cyc), 32'(lat));
    ld  = bus.loadData;
    mis = bus.misaligned;
    check("misaligned", {31'b0, mis}, {31'b0, m});
    if (!m && op <= 3'd4) exp_load = exp_ld(op, a);
    check("load_data", ld, exp_load);
    if (!m && op >= 3'd5) apply_store(op, a, d);
    if (inject) begin
      bus.start = 1'b1;
      bus.op    = 3'd5;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_done", {31'b0, bus.busy}, 32'd0);
    check("read_cycles", 32'(rd_cycles), (m || op == 3'd5) ? 32'd0 : 32'd1);
    check("write_cycles", 32'(wr_cycles), (!m && op >= 3'd5) ? 32'd1 : 32'd0);
    check("mem_word", mem[w], mword(w));
  endtask

  logic [31:0] ld;
  logic        mis;

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 3'd0;
    bus.addr      = 32'd0;
    bus.storeData = 32'd0;
    exp_load      = 32'd0;
    for (int i = 0; i < 256; i++) set_word(i, $urandom);
    set_word(82, 32'h000001B0);
    set_word(83, 32'hFFFFFF86);
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_mis", {31'b0, bus.misaligned}, 32'd0);
    check("rst_rw", {30'b0, bus.memRead, bus.memWrite}, 32'd0);
    check("rst_load", bus.loadData, 32'd0);
    check("rst_dout", bus.memDataOut, 32'd0);
    check("rst_maddr", bus.memAddress, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_req(3'd0, 32'h148, 32'h0, 1'b0, ld, mis);
    check("lit_lw", ld, 32'h000001B0);
    do_req(3'd3, 32'h14B, 32'h0, 1'b0, ld, mis);
    check("lit_lb", ld, 32'hFFFFFFB0);
    do_req(3'd4, 32'h14B, 32'h0, 1'b0, ld, mis);
    check("lit_lbu", ld, 32'h000000B0);
    do_req(3'd1, 32'h14E, 32'h0, 1'b0, ld, mis);
    check("lit_lh", ld, 32'hFFFFFF86);
    do_req(3'd2, 32'h14E, 32'h0, 1'b0, ld, mis);
    check("lit_lhu", ld, 32'h0000FF86);
    do_req(3'd0, 32'h149, 32'h0, 1'b0, ld, mis);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lit_mis_flag", {31'b0, mis}, 32'd1);
    check("lit_mis_load", ld, 32'h0000FF86);
`else
    check("lit_mis_flag", {31'b0, mis}, 32'd0);
    check("lit_mis_load", ld, 32'h000001B0);
`endif
    do_req(3'd0, 32'h148, 32'h0, 1'b1, ld, mis);
    check("lit_ignored_start", ld, 32'h000001B0);
    do_req(3'd6, 32'h148, 32'h1234ABCD, 1'b0, ld, mis);
    check("lit_sh", mem[82], 32'hABCD01B0);
    do_req(3'd7, 32'h14A, 32'h000000EE, 1'b0, ld, mis);
    check("lit_sb", mem[82], 32'hABCDEEB0);

    // Reset lands while an SW sits in its write cycle.
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = 3'd5;
    bus.addr      = 32'h148;
    bus.storeData = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("sw_write_cycle", {31'b0, bus.memWrite}, 32'd1);
    reset = 1'b1;
    #1;
    check("write_gated", {31'b0, bus.memWrite}, 32'd0);
    @(posedge clk);
    #1;
    exp_load = 32'd0;
    check("mid_rst_flags", {28'b0, bus.done, bus.busy, bus.memRead, bus.memWrite}, 32'd0);
    check("mid_rst_mis", {31'b0, bus.misaligned}, 32'd0);
    check("mid_rst_load", bus.loadData, 32'd0);
    check("mid_rst_dout", bus.memDataOut, 32'd0);
    check("mid_rst_maddr", bus.memAddress, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_mem", mem[82], 32'hABCDEEB0);

    for (int i = 0; i < 200; i++) begin
      do_req(3'($urandom), 32'($urandom_range(0, 1023)), $urandom, 1'(($urandom % 8) == 0),
             ld, mis);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
